// File: rtl/neurosync_medida_seq_if.sv
// Bus between the NeuroSync measurement sequencer, the game control unit and the servo/sonar sub-blocks.
// The sequencer connects as slave; the control side (or a bench) drives the request and sonar inputs.
interface neurosync_medida_seq_if #(
    parameter int DIST_W = 9
);
    logic              zera;
    logic              medir;
    logic [1:0]        posicao;
    logic [DIST_W-1:0] faixa_min;
    logic [DIST_W-1:0] faixa_max;
    logic              pronto_sonar;
    logic [DIST_W-1:0] medida;
    logic [1:0]        pos_servo;
    logic              mede;
    logic              ocupado;
    logic              pronto;
    logic              acertou_faixa;
    logic              erro_timeout;
    logic [DIST_W-1:0] ultima_medida;
    logic [3:0]        db_estado;

    modport slave (
        input  zera, medir, posicao, faixa_min, faixa_max, pronto_sonar, medida,
        output pos_servo, mede, ocupado, pronto, acertou_faixa, erro_timeout,
               ultima_medida, db_estado
    );

    modport master (
        output zera, medir, posicao, faixa_min, faixa_max, pronto_sonar, medida,
        input  pos_servo, mede, ocupado, pronto, acertou_faixa, erro_timeout,
               ultima_medida, db_estado
    );
endinterface

// File: rtl/neurosync_medida_seq.sv
// Measurement sequencer: positions the servo, waits for it to settle, fires the sonar with
// timeout/retry, and classifies the returned distance against an inclusive target window.
module neurosync_medida_seq #(
    parameter int SETTLE_CYCLES  = 25000000,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int MAX_TENTATIVAS = 3,
    parameter int DIST_W         = 9
) (
    input  logic                 clock,
    input  logic                 reset,
    neurosync_medida_seq_if.slave bus
);
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TENT_W  = $clog2(MAX_TENTATIVAS + 1);

    localparam logic [CNT_W-1:0]  SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_FINAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [TENT_W-1:0] TENT_MAX      = TENT_W'(MAX_TENTATIVAS);

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        POSICIONA    = 4'd1,
        ESPERA_SERVO = 4'd2,
        DISPARA      = 4'd3,
        AGUARDA      = 4'd4,
        COMPARA      = 4'd5,
        FIM          = 4'd6,
        ERRO         = 4'd7
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TENT_W-1:0] tent_q, tent_d;
    logic [1:0]        pos_lat_q, pos_lat_d;
    logic [1:0]        pos_servo_q, pos_servo_d;
    logic [DIST_W-1:0] fmin_q, fmin_d;
    logic [DIST_W-1:0] fmax_q, fmax_d;
    logic [DIST_W-1:0] ultima_q, ultima_d;
    logic              acertou_q, acertou_d;
    logic              erro_q, erro_d;

    logic ultima_tentativa;
    logic expira;

    // The final attempt waits one extra cycle so the error pulse lands one cycle after the slot
    // where a further retry would have fired.
    assign ultima_tentativa = (tent_q >= TENT_MAX);
    assign expira = (cnt_q == (ultima_tentativa ? TIMEOUT_FINAL : TIMEOUT_LAST));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tent_q      <= '0;
            pos_lat_q   <= '0;
            pos_servo_q <= '0;
            fmin_q      <= '0;
            fmax_q      <= '0;
            ultima_q    <= '0;
            acertou_q   <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tent_q      <= tent_d;
            pos_lat_q   <= pos_lat_d;
            pos_servo_q <= pos_servo_d;
            fmin_q      <= fmin_d;
            fmax_q      <= fmax_d;
            ultima_q    <= ultima_d;
            acertou_q   <= acertou_d;
            erro_q      <= erro_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (bus.zera) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:         if (bus.medir) state_d = POSICIONA;
                POSICIONA:    state_d = ESPERA_SERVO;
                ESPERA_SERVO: if (cnt_q == SETTLE_LAST) state_d = DISPARA;
                DISPARA:      state_d = AGUARDA;
                AGUARDA: begin
                    if (bus.pronto_sonar) state_d = COMPARA;
                    else if (expira)      state_d = ultima_tentativa ? ERRO : DISPARA;
                end
                COMPARA:      state_d = FIM;
                FIM:          state_d = IDLE;
                ERRO:         state_d = IDLE;
                default:      state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        tent_d      = tent_q;
        pos_lat_d   = pos_lat_q;
        pos_servo_d = pos_servo_q;
        fmin_d      = fmin_q;
        fmax_d      = fmax_q;
        ultima_d    = ultima_q;
        acertou_d   = acertou_q;
        erro_d      = erro_q;

        case (state_q)
            IDLE: begin
                if (bus.medir) begin
                    pos_lat_d = bus.posicao;
                    fmin_d    = bus.faixa_min;
                    fmax_d    = bus.faixa_max;
                    acertou_d = 1'b0;
                    erro_d    = 1'b0;
                    tent_d    = '0;
                end
            end
            POSICIONA: begin
                pos_servo_d = pos_lat_q;
                cnt_d       = '0;
            end
            ESPERA_SERVO: begin
                if (cnt_q != SETTLE_LAST) cnt_d = cnt_q + 1'b1;
            end
            DISPARA: begin
                tent_d = tent_q + 1'b1;
                cnt_d  = '0;
            end
            AGUARDA: begin
                if (bus.pronto_sonar) begin
                    ultima_d = bus.medida;
                end else if (expira) begin
                    if (ultima_tentativa) begin
                        erro_d    = 1'b1;
                        acertou_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMPARA: begin
                // An inverted window (min > max) can never satisfy both bounds.
                acertou_d = (fmin_q <= ultima_q) && (ultima_q <= fmax_q);
            end
            default: ;
        endcase

        if (bus.zera) begin
            cnt_d     = '0;
            tent_d    = '0;
            pos_lat_d = '0;
            fmin_d    = '0;
            fmax_d    = '0;
            ultima_d  = '0;
            acertou_d = 1'b0;
            erro_d    = 1'b0;
        end
    end

    always_comb begin
        bus.pos_servo     = pos_servo_q;
        bus.mede          = (state_q == DISPARA);
        bus.ocupado       = (state_q != IDLE);
        bus.pronto        = (state_q == FIM) || (state_q == ERRO);
        bus.acertou_faixa = acertou_q;
        bus.erro_timeout  = erro_q;
        bus.ultima_medida = ultima_q;
        bus.db_estado     = state_q;
    end
endmodule

// File: tb/tb_neurosync_medida_seq.sv
// Scoreboard bench for neurosync_medida_seq: expected results are queued as sonar replies are
// driven and compared when the sequencer pulses pronto; cycle distances are checked against the timing.
module tb_neurosync_medida_seq;
    localparam int S    = 4;
    localparam int T    = 8;
    localparam int MAXT = 3;
    localparam int DW   = 9;

    typedef struct packed {
        logic          acert;
        logic          erro;
        logic [DW-1:0] ult;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    neurosync_medida_seq_if #(.DIST_W(DW)) bus ();

    neurosync_medida_seq #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T),
        .MAX_TENTATIVAS(MAXT),
        .DIST_W        (DW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    exp_t          sb[$];
    int            mede_log[$];
    int            pronto_log[$];
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_ult  = '0;
    exp_t          mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.mede) mede_log.push_back(cyc);
        if (bus.pronto) begin
            pronto_log.push_back(cyc);
            if (sb.size() == 0) begin
                check("pronto_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("acertou_faixa", bus.acertou_faixa, mon_e.acert);
                check("erro_timeout", bus.erro_timeout, mon_e.erro);
                check("ultima_medida", bus.ultima_medida, mon_e.ult);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_mede(output int c, input string tag);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mede_log.size() > 0) begin
                c = mede_log.pop_front();
                break;
            end
        end
        if (c < 0) check({tag, "_mede_missing"}, 0, 1);
    endtask

    task automatic wait_pronto(output int c, input string tag);
        c = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (pronto_log.size() > 0) begin
                c = pronto_log.pop_front();
                break;
            end
        end
        if (c < 0) check({tag, "_pronto_missing"}, 0, 1);
    endtask

    task automatic start(input logic [1:0] pos, input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                         output int k);
        bus.posicao   = pos;
        bus.faixa_min = lo;
        bus.faixa_max = hi;
        bus.medir     = 1'b1;
        tick();
        bus.medir = 1'b0;
        k = cyc;
    endtask

    task automatic reply_now(input logic [DW-1:0] med, input logic hit, output int drv);
        exp_t e;
        bus.medida       = med;
        bus.pronto_sonar = 1'b1;
        drv              = cyc;
        e.acert          = hit;
        e.erro           = 1'b0;
        e.ult            = med;
        sb.push_back(e);
        exp_ult = med;
        tick();
        bus.pronto_sonar = 1'b0;
    endtask

    task automatic idle_after(input string tag);
        tick();
        check({tag, "_pronto_single"}, bus.pronto, 0);
        check({tag, "_ocupado_idle"}, bus.ocupado, 0);
        check({tag, "_no_extra_mede"}, mede_log.size(), 0);
    endtask

    task automatic do_meas(input string tag, input logic [1:0] pos, input logic [DW-1:0] lo,
                           input logic [DW-1:0] hi, input int n_retry, input bit reply,
                           input int d, input logic [DW-1:0] med, input logic hit);
        int   k, m0, m, mp, p, drv;
        exp_t e;
        start(pos, lo, hi, k);
        wait_mede(m0, tag);
        check({tag, "_mede_latency"}, m0 - k, S + 1);
        check({tag, "_pos_servo"}, bus.pos_servo, pos);
        m = m0;
        if (reply) begin
            for (int i = 0; i < n_retry; i++) begin
                wait_mede(mp, tag);
                check({tag, "_retry_gap"}, mp - m, T + 1);
                m = mp;
            end
            repeat (d) tick();
            reply_now(med, hit, drv);
            wait_pronto(p, tag);
            check({tag, "_pronto_latency"}, p - drv, 2);
        end else begin
            for (int i = 1; i < MAXT; i++) begin
                wait_mede(mp, tag);
                check({tag, "_retry_gap"}, mp - m, T + 1);
                m = mp;
            end
            e.acert = 1'b0;
            e.erro  = 1'b1;
            e.ult   = exp_ult;
            sb.push_back(e);
            wait_pronto(p, tag);
            check({tag, "_error_latency"}, p - m0, MAXT * (T + 1) + 1);
        end
        idle_after(tag);
    endtask

    task automatic abort_test(input string tag, input bit use_reset);
        int k, m;
        start(2'd1, 9'd10, 9'd20, k);
        wait_mede(m, tag);
        repeat (2) tick();
        if (use_reset) reset = 1'b1;
        else           bus.zera = 1'b1;
        tick();
        reset    = 1'b0;
        bus.zera = 1'b0;
        exp_ult  = '0;
        check({tag, "_ocupado"}, bus.ocupado, 0);
        check({tag, "_db_estado"}, bus.db_estado, 0);
        check({tag, "_mede"}, bus.mede, 0);
        check({tag, "_pos_servo"}, bus.pos_servo, use_reset ? 0 : 1);
        check({tag, "_acertou"}, bus.acertou_faixa, 0);
        check({tag, "_ultima"}, bus.ultima_medida, 0);
        repeat (2) tick();
        bus.medida       = 9'd77;
        bus.pronto_sonar = 1'b1;
        tick();
        bus.pronto_sonar = 1'b0;
        repeat (4) tick();
        check({tag, "_no_pronto"}, pronto_log.size(), 0);
        check({tag, "_late_reply_ignored"}, bus.ultima_medida, 0);
        check({tag, "_still_idle"}, bus.ocupado, 0);
        check({tag, "_no_mede"}, mede_log.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k, m, drv, p;
        bus.zera         = 1'b0;
        bus.medir        = 1'b0;
        bus.posicao      = '0;
        bus.faixa_min    = '0;
        bus.faixa_max    = '0;
        bus.pronto_sonar = 1'b0;
        bus.medida       = '0;

        repeat (3) tick();
        check("rst_pos_servo", bus.pos_servo, 0);
        check("rst_ocupado", bus.ocupado, 0);
        check("rst_mede", bus.mede, 0);
        check("rst_pronto", bus.pronto, 0);
        check("rst_acertou", bus.acertou_faixa, 0);
        check("rst_erro", bus.erro_timeout, 0);
        check("rst_ultima", bus.ultima_medida, 0);
        check("rst_db_estado", bus.db_estado, 0);
        reset = 1'b0;
        tick();
        check("post_rst_idle", bus.ocupado, 0);

        do_meas("hit",      2'd2, 9'd10, 9'd20, 0, 1'b1, 3, 9'd15, 1'b1);
        do_meas("lo_edge",  2'd2, 9'd10, 9'd20, 0, 1'b1, 3, 9'd10, 1'b1);
        do_meas("hi_edge",  2'd2, 9'd10, 9'd20, 0, 1'b1, 3, 9'd20, 1'b1);
        do_meas("above",    2'd2, 9'd10, 9'd20, 0, 1'b1, 3, 9'd21, 1'b0);
        do_meas("inverted", 2'd1, 9'd30, 9'd5,  0, 1'b1, 1, 9'd10, 1'b0);
        do_meas("retry",    2'd2, 9'd10, 9'd20, 1, 1'b1, 2, 9'd12, 1'b1);
        do_meas("timeout",  2'd3, 9'd10, 9'd20, 0, 1'b0, 0, 9'd0,  1'b0);
        do_meas("expiry",   2'd0, 9'd5,  9'd50, 0, 1'b1, T, 9'd40, 1'b1);

        // Requests while busy must not disturb the running measurement or its latched window.
        start(2'd2, 9'd10, 9'd20, k);
        bus.posicao   = 2'd3;
        bus.faixa_min = 9'd0;
        bus.faixa_max = 9'd5;
        bus.medir     = 1'b1;
        tick();
        bus.medir = 1'b0;
        wait_mede(m, "busy");
        check("busy_mede_latency", m - k, S + 1);
        check("busy_pos_servo", bus.pos_servo, 2);
        bus.medir = 1'b1;
        tick();
        bus.medir = 1'b0;
        tick();
        reply_now(9'd15, 1'b1, drv);
        wait_pronto(p, "busy");
        check("busy_pronto_latency", p - drv, 2);
        idle_after("busy");

        abort_test("zera", 1'b0);
        abort_test("reset", 1'b1);

        do_meas("recover",  2'd2, 9'd10, 9'd20, 0, 1'b1, 5, 9'd11, 1'b1);

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
